pwm_width_decoder: RTL and testbench

//  Receive-side partner of the frequency-scaling PWM generator: samples a 500 Hz PWM line
//  (2 ms period, 20 units of 100 us) on the 50 MHz system clock. Recovers the 4-bit pulse

---
 rtl/pwm_width_decoder_if.sv | 23 ++
 rtl/pwm_width_decoder.sv | 188 ++++++++++++++++++
 tb/tb_pwm_width_decoder.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_width_decoder_if.sv
// PWM decoder port bundle: the sampled PWM line plus the decoded width/status outputs.
// Latency: none (wires only).
// Backpressure: none; width_valid is a one-cycle strobe that the consumer must take when it fires.
interface pwm_width_decoder_if;
  logic       pwm_in;
  logic [3:0] pulse_width;
  logic       width_valid;
  logic       width_ovf;
  logic       period_err;
  logic       signal_lost;

  // Driver of the PWM line / consumer of the decoded result
  modport master (
    output pwm_in,
    input  pulse_width, width_valid, width_ovf, period_err, signal_lost
  );

  // The decoder itself
  modport slave (
    input  pwm_in,
    output pulse_width, width_valid, width_ovf, period_err, signal_lost
  );
endinterface

// File: rtl/pwm_width_decoder.sv
// PWM width decoder: recovers the high time (in units), checks the period and flags a lost signal.
// Latency: width_valid 3 clk after the raw rise that closes a period (+FILTER_CYCLES with PWM_GLITCH_FILTER_EN).
// Backpressure: none; results are strobed and held until the next period closes.
module pwm_width_decoder #(
  parameter int UNIT_CYCLES   = 5000,
  parameter int PERIOD_UNITS  = 20,
  parameter int PERIOD_TOL    = 1,
  parameter int TIMEOUT_UNITS = 40,
  parameter int FILTER_CYCLES = 8
) (
  input  logic               clk_50MHz,
  input  logic               rst_n,
  pwm_width_decoder_if.slave pwm_if
);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  localparam logic [12:0] SUB_LAST = 13'(UNIT_CYCLES - 1);
  localparam logic [12:0] SUB_HALF = 13'(UNIT_CYCLES / 2);
  localparam logic [5:0]  TO_LAST  = 6'(TIMEOUT_UNITS - 1);
  localparam logic [6:0]  P_MIN    = 7'(PERIOD_UNITS - PERIOD_TOL);
  localparam logic [6:0]  P_MAX    = 7'(PERIOD_UNITS + PERIOD_TOL);

  state_t      r_state, w_state_nxt;
  logic        r_sync1, r_sync2, r_pwm_d;
  logic [2:0]  r_fill;
  logic [12:0] r_sub_cnt;
  logic [5:0]  r_hi, r_lo, r_hi_lat, r_to_cnt;
  logic [3:0]  r_pw;
  logic        r_vld, r_ovf, r_err, r_lost;
  logic        w_pwm_s, w_edge_ok, w_rise, w_fall, w_edge, w_wrap, w_round;
  logic [5:0]  w_hi_rnd, w_lo_rnd;
  logic [6:0]  w_period;
  logic        w_to_hit, w_clr_units, w_latch_hi, w_strobe, w_timeout;

  // Synchronize the PWM line; r_fill masks edges until the pipeline holds real samples,
  // so a line that is already high at reset release does not look like a rise.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_pwm_d <= 1'b0;
      r_fill  <= 3'd0;
    end else begin
      r_sync1 <= pwm_if.pwm_in;
      r_sync2 <= r_sync1;
      r_pwm_d <= w_pwm_s;
      if (r_fill != 3'd4) r_fill <= r_fill + 3'd1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int              FW        = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0]   FILT_LAST = FW'(FILTER_CYCLES - 1);
  logic [FW-1:0] r_filt_cnt;
  logic          r_filt;

  // Accept a new level only after it has been stable for FILTER_CYCLES clocks
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_cnt <= '0;
      r_filt     <= 1'b0;
    end else if (r_fill < 3'd3) begin
      r_filt     <= r_sync2;
      r_filt_cnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FILT_LAST) begin
      r_filt     <= r_sync2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end
  assign w_pwm_s = r_filt;
`else
  assign w_pwm_s = r_sync2;
`endif

  assign w_edge_ok = (r_fill == 3'd4);
  assign w_rise    = w_edge_ok &  w_pwm_s & ~r_pwm_d;
  assign w_fall    = w_edge_ok & ~w_pwm_s &  r_pwm_d;
  assign w_edge    = w_rise | w_fall;
  // An edge in the wrap cycle wins; the unit it would have added comes back via rounding
  assign w_wrap    = (r_sub_cnt == SUB_LAST) && !w_edge;
  assign w_round   = (r_sub_cnt >= SUB_HALF);
  assign w_hi_rnd  = (w_round && r_hi != 6'd63) ? r_hi + 6'd1 : r_hi;
  assign w_lo_rnd  = (w_round && r_lo != 6'd63) ? r_lo + 6'd1 : r_lo;
  assign w_period  = {1'b0, r_hi_lat} + {1'b0, w_lo_rnd};
  assign w_to_hit  = (r_state != ST_IDLE) && w_wrap && (r_to_cnt == TO_LAST);

  // FSM state register
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_clr_units = 1'b0;
    w_latch_hi  = 1'b0;
    w_strobe    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_HIGH;
          w_clr_units = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_to_hit) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end else if (w_fall) begin
          w_state_nxt = ST_LOW;
          w_latch_hi  = 1'b1;
        end
      end
      ST_LOW: begin
        if (w_to_hit) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end else if (w_rise) begin
          w_state_nxt = ST_HIGH;
          w_strobe    = 1'b1;
          w_clr_units = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Timebase, unit counters and timeout counter
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_cnt <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hi_lat  <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_sub_cnt <= (w_edge || r_sub_cnt == SUB_LAST) ? 13'd0 : r_sub_cnt + 13'd1;
      if (w_clr_units)
        r_hi <= '0;
      else if (r_state == ST_HIGH && w_wrap && r_hi != 6'd63)
        r_hi <= r_hi + 6'd1;
      if (w_clr_units || w_latch_hi)
        r_lo <= '0;
      else if (r_state == ST_LOW && w_wrap && r_lo != 6'd63)
        r_lo <= r_lo + 6'd1;
      if (w_latch_hi) r_hi_lat <= w_hi_rnd;
      if (w_rise)
        r_to_cnt <= '0;
      else if (r_state != ST_IDLE && w_wrap && r_to_cnt != 6'd63)
        r_to_cnt <= r_to_cnt + 6'd1;
    end
  end

  // Result registers: updated on period close, signal_lost set on timeout
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pw   <= '0;
      r_vld  <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      r_vld <= w_strobe;
      if (w_strobe) begin
        r_pw   <= (r_hi_lat > 6'd15) ? 4'd15 : r_hi_lat[3:0];
        r_ovf  <= (r_hi_lat > 6'd15);
        r_err  <= (w_period < P_MIN) || (w_period > P_MAX);
        r_lost <= 1'b0;
      end else if (w_timeout) begin
        r_lost <= 1'b1;
      end
    end
  end

  assign pwm_if.pulse_width = r_pw;
  assign pwm_if.width_valid = r_vld;
  assign pwm_if.width_ovf   = r_ovf;
  assign pwm_if.period_err  = r_err;
  assign pwm_if.signal_lost = r_lost;

endmodule

// File: tb/tb_pwm_width_decoder.sv
// Bench for pwm_width_decoder with a shortened unit (20 clk) so full periods stay cheap.
// Stimulus is driven as timed PWM segments; a period model pushes expected results on each rise.
// Strobes are popped and compared as they appear; scenario tasks add their own direct checks.
module tb_pwm_width_decoder;
  localparam int U = 20;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int MIN_SEG = 8;
`else
  localparam int MIN_SEG = 1;
`endif

  typedef struct {
    int pw;
    bit ovf;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  pwm_width_decoder_if pif();

  pwm_width_decoder #(
    .UNIT_CYCLES(U), .PERIOD_UNITS(20), .PERIOD_TOL(1),
    .TIMEOUT_UNITS(40), .FILTER_CYCLES(8)
  ) dut (
    .clk_50MHz(clk),
    .rst_n(rst_n),
    .pwm_if(pif)
  );

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe = -1;
  int strobe_gap = 0;
  int n_strobes = 0;
  bit prev_vld = 1'b0;
  // period model
  int m_state = 0;   // 0 idle, 1 high, 2 low
  bit m_lvl = 1'b0;
  int m_hi = 0;
  int m_lo = 0;
  int m_last_pw = 0;

  function automatic int units(input int n);
    int u;
    u = (n - 1 + U / 2) / U;
    return (u > 63) ? 63 : u;
  endfunction

  function automatic exp_t calc(input int hc, input int lc);
    exp_t e;
    int h, l, d;
    h = units(hc);
    l = units(lc);
    d = h + l - 20;
    if (d < 0) d = -d;
    e.pw  = (h > 15) ? 15 : h;
    e.ovf = (h > 15);
    e.err = (d > 1);
    return e;
  endfunction

  // One clock: sample at the falling edge and pop the scoreboard on every strobe
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst_n && pif.width_valid) begin
      n_strobes++;
      strobe_gap = cyc - last_strobe;
      last_strobe = cyc;
      checks++;
      if (prev_vld) begin
        errors++;
        $display("FAIL strobe_back_to_back at cycle %0d: width_valid high two cycles, required one", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected at cycle %0d: got pw=%0d, required no strobe", cyc, pif.pulse_width);
      end else begin
        e = exp_q.pop_front();
        if ({pif.pulse_width, pif.width_ovf, pif.period_err, pif.signal_lost} !==
            {e.pw[3:0], e.ovf, e.err, 1'b0}) begin
          errors++;
          $display("FAIL strobe_result at cycle %0d: got pw=%0d ovf=%0b err=%0b lost=%0b, required pw=%0d ovf=%0b err=%0b lost=0",
                   cyc, pif.pulse_width, pif.width_ovf, pif.period_err, pif.signal_lost, e.pw, e.ovf, e.err);
        end
      end
    end
    prev_vld = rst_n && pif.width_valid;
  endtask

  // Drive one level for n clocks and advance the period model
  task automatic drive_seg(input bit level, input int n);
    exp_t e;
    if (level != m_lvl && n >= MIN_SEG) begin
      if (level) begin
        if (m_state == 2) begin
          e = calc(m_hi, m_lo);
          exp_q.push_back(e);
          m_last_pw = e.pw;
        end
        m_state = 1;
        m_hi = 0;
      end else if (m_state == 1) begin
        m_state = 2;
        m_lo = 0;
      end
      m_lvl = level;
    end
    if (m_state == 1) m_hi += n;
    else if (m_state == 2) m_lo += n;
    pif.pwm_in = level;
    repeat (n) step();
  endtask

  task automatic drive_period(input int hi_u, input int per_u);
    drive_seg(1'b1, hi_u * U);
    drive_seg(1'b0, (per_u - hi_u) * U);
  endtask

  task automatic test_reset();
    pif.pwm_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({pif.pulse_width, pif.width_valid, pif.width_ovf, pif.period_err, pif.signal_lost} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got pw=%0d vld=%0b ovf=%0b err=%0b lost=%0b, required all 0",
               pif.pulse_width, pif.width_valid, pif.width_ovf, pif.period_err, pif.signal_lost);
    end
    rst_n = 1'b1;
    repeat (10) step();
    checks++;
    if (n_strobes != 0) begin
      errors++;
      $display("FAIL reset_idle_strobe: got %0d strobes, required 0", n_strobes);
    end
  endtask

  task automatic test_nominal();
    int n0;
    n0 = n_strobes;
    for (int i = 0; i < 5; i++) drive_period(8, 20);
    checks++;
    if (n_strobes - n0 != 4) begin
      errors++;
      $display("FAIL nominal_count: got %0d strobes, required 4", n_strobes - n0);
    end
    checks++;
    if (strobe_gap != 20 * U) begin
      errors++;
      $display("FAIL nominal_interval: got %0d clk, required %0d", strobe_gap, 20 * U);
    end
    checks++;
    if (pif.pulse_width !== 4'd8) begin
      errors++;
      $display("FAIL nominal_width: got %0d, required 8", pif.pulse_width);
    end
  endtask

  task automatic test_width_seq();
    int w[7] = '{11, 4, 12, 4, 5, 9, 13};
    for (int i = 0; i < 7; i++) drive_period(w[i], 20);
    checks++;
    if (pif.pulse_width !== 4'd9) begin
      errors++;
      $display("FAIL seq_lag: got %0d, required 9 (one period behind)", pif.pulse_width);
    end
  endtask

  task automatic test_timeout();
    int t0, dt;
    bit seen;
    t0 = cyc;
    drive_seg(1'b1, 8 * U);
    drive_seg(1'b0, 30 * U);
    checks++;
    if (pif.signal_lost !== 1'b0) begin
      errors++;
      $display("FAIL lost_early: got 1 at 38 units, required 0");
    end
    seen = 1'b0;
    for (int i = 0; i < 15 * U && !seen; i++) begin
      step();
      seen = pif.signal_lost;
    end
    dt = cyc - t0;
    checks++;
    if (!seen || dt < 40 * U || dt > 43 * U) begin
      errors++;
      $display("FAIL lost_low_timing: got lost=%0b after %0d clk, required 1 within %0d..%0d", seen, dt, 40 * U, 43 * U);
    end
    checks++;
    if (pif.pulse_width !== 4'(m_last_pw)) begin
      errors++;
      $display("FAIL lost_hold_width: got %0d, required %0d", pif.pulse_width, m_last_pw);
    end
    m_state = 0;
    drive_period(5, 20);
    checks++;
    if (pif.signal_lost !== 1'b1) begin
      errors++;
      $display("FAIL lost_first_rise: got 0 after one rise, required 1");
    end
    drive_period(5, 20);
    drive_period(5, 20);
    checks++;
    if (pif.signal_lost !== 1'b0 || pif.pulse_width !== 4'd5) begin
      errors++;
      $display("FAIL lost_recover: got lost=%0b pw=%0d, required lost=0 pw=5", pif.signal_lost, pif.pulse_width);
    end
    drive_seg(1'b1, 45 * U);
    m_state = 0;
    checks++;
    if (pif.signal_lost !== 1'b1 || pif.pulse_width !== 4'd5) begin
      errors++;
      $display("FAIL lost_high: got lost=%0b pw=%0d, required lost=1 pw=5", pif.signal_lost, pif.pulse_width);
    end
    drive_seg(1'b0, 12 * U);
    drive_period(8, 20);
    drive_period(8, 20);
  endtask

  task automatic test_period_err();
    drive_period(6, 25);
    drive_period(17, 20);
    drive_seg(1'b1, U);
    checks++;
    if (pif.pulse_width !== 4'd15 || pif.width_ovf !== 1'b1 || pif.period_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_17: got pw=%0d ovf=%0b err=%0b, required pw=15 ovf=1 err=0",
               pif.pulse_width, pif.width_ovf, pif.period_err);
    end
    drive_seg(1'b1, 7 * U);
    drive_seg(1'b0, 12 * U);
    drive_period(8, 20);
  endtask

  task automatic test_glitch();
    bit exp_err;
`ifdef PWM_GLITCH_FILTER_EN
    exp_err = 1'b0;
`else
    exp_err = 1'b1;
`endif
    drive_seg(1'b1, 4 * U);
    drive_seg(1'b0, 3);
    drive_seg(1'b1, 4 * U - 3);
    drive_seg(1'b0, 12 * U);
    drive_seg(1'b1, U);
    checks++;
    if (pif.period_err !== exp_err) begin
      errors++;
      $display("FAIL glitch_period: got err=%0b pw=%0d, required err=%0b", pif.period_err, pif.pulse_width, exp_err);
    end
    drive_seg(1'b1, 7 * U);
    drive_seg(1'b0, 12 * U);
    drive_period(8, 20);
  endtask

  task automatic test_reset_mid();
    int n0;
    drive_seg(1'b1, 4 * U);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pif.pulse_width, pif.width_valid, pif.width_ovf, pif.period_err, pif.signal_lost} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_outputs: got pw=%0d vld=%0b ovf=%0b err=%0b lost=%0b, required all 0",
               pif.pulse_width, pif.width_valid, pif.width_ovf, pif.period_err, pif.signal_lost);
    end
    repeat (3) step();
    exp_q.delete();
    m_state = 0;
    rst_n = 1'b1;
    n0 = n_strobes;
    drive_seg(1'b1, 4 * U);
    drive_seg(1'b0, 12 * U);
    drive_period(7, 20);
    checks++;
    if (n_strobes != n0) begin
      errors++;
      $display("FAIL reset_mid_first_rise: got %0d strobes, required 0", n_strobes - n0);
    end
    drive_period(7, 20);
    checks++;
    if (n_strobes != n0 + 1 || pif.pulse_width !== 4'd7) begin
      errors++;
      $display("FAIL reset_mid_second_rise: got %0d strobes pw=%0d, required 1 strobe pw=7", n_strobes - n0, pif.pulse_width);
    end
  endtask

  task automatic test_drain();
    drive_seg(1'b1, 2 * U);
    drive_seg(1'b0, U);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    pif.pwm_in = 1'b0;
    test_reset();
    test_nominal();
    test_width_seq();
    test_timeout();
    test_period_err();
    test_glitch();
    test_reset_mid();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
